rom_search_arbiter: RTL and testbench

Shares one sequential ROM search engine between `N_REQ` requesters. Each requester posts an 8-bit search key. The arbiter grants one requester at a time in round-robin order, drives the engine's key and start strobe, and holds the key stable for the whole search. When the engine finishes, it returns the engine's address and match result to the winner with a one-cycle done pulse. It sits between the client logic and the search engine, and is the only block allowed to drive the engine's `start_search`/`data` inputs.

---
 rtl/rom_search_pkg.sv | 21 ++
 rtl/rom_search_arbiter_rr_picker.sv | 33 +++
 rtl/rom_search_arbiter.sv | 110 +++++++++++
 tb/tb_rom_search_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_search_pkg.sv
// Shared types and defaults for the ROM search arbiter.
// Provides the FSM state type, width defaults and a counter-width helper.
package rom_search_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 512;

  // Bits needed to count 0 .. t-1 (at least one bit).
  function automatic int cnt_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/rom_search_arbiter_rr_picker.sv
// Combinational round-robin select: scans req from ptr upward, wrapping.
// Ports: req, ptr in; onehot winner and its index out.
module rr_picker
  import rom_search_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx
);

  always_comb begin
    logic found;
    int   p;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    p      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      p = int'(ptr) + k;
      if (p >= N_REQ) p = p - N_REQ;
      if (!found && req[p]) begin
        found     = 1'b1;
        onehot[p] = 1'b1;
        idx       = PW'(p);
      end
    end
  end

endmodule

// File: rtl/rom_search_arbiter.sv
// Round-robin arbiter sharing one sequential ROM search engine.
// Ports: req/req_data from clients; grant/done/rsp_* back; eng_* to/from engine.
module rom_search_arbiter
  import rom_search_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_a,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [ADDR_W-1:0]       rsp_address,
  output logic                    rsp_match,
  output logic                    rsp_timeout,
  output logic [DATA_W-1:0]       eng_data,
  output logic                    eng_start,
  input  logic                    eng_busy,
  input  logic [ADDR_W-1:0]       eng_address,
  input  logic                    eng_match
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = cnt_w(TIMEOUT);

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [N_REQ-1:0]  pick_hot;
  logic [PW-1:0]     pick_idx;
  logic [DATA_W-1:0] pick_key;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_hot),
    .idx    (pick_idx)
  );

  always_comb begin
    pick_key = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PW'(i))
        pick_key = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      done        <= '0;
      rsp_address <= '0;
      rsp_match   <= 1'b0;
      rsp_timeout <= 1'b0;
      eng_data    <= '0;
      eng_start   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      done      <= '0;
      unique case (state)
        IDLE: begin
          // A busy engine here is a search left over from a reset.
          if (|req && !eng_busy) begin
            grant     <= pick_hot;
            eng_data  <= pick_key;
            eng_start <= 1'b1;
            ptr       <= (pick_idx == PW'(N_REQ-1))
                         ? '0 : pick_idx + 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!eng_busy) begin
            rsp_address <= eng_address;
            rsp_match   <= eng_match;
            rsp_timeout <= 1'b0;
            done        <= grant;
            state       <= DONE;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            rsp_match   <= 1'b0;
            rsp_timeout <= 1'b1;
            done        <= grant;
            state       <= DONE;
          end
        end
        DONE: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_search_arbiter.sv
// Directed bench for rom_search_arbiter with a behavioural ROM search engine.
// A second instance (TIMEOUT=16) has a bench-driven engine for stall cases.
module tb_rom_search_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2;
  logic [3:0]  req, req2;
  logic [31:0] req_data, req_data2;

  logic [3:0] grant, done, grant2, done2;
  logic [7:0] rsp_address, rsp_address2;
  logic       rsp_match, rsp_timeout, rsp_match2, rsp_timeout2;
  logic [7:0] eng_data, eng_data2;
  logic       eng_start, eng_start2;

  logic       e_busy  = 1'b0;
  logic       e_match = 1'b0;
  logic [7:0] e_addr  = 8'h00;
  logic [7:0] e_key   = 8'h00;
  logic [7:0] rom [256];

  logic       busy2;
  logic [7:0] addr2  = 8'h77;
  logic       match2 = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc;

  rom_search_arbiter dut (
    .clk         (clk),
    .rst_a       (rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .done        (done),
    .rsp_address (rsp_address),
    .rsp_match   (rsp_match),
    .rsp_timeout (rsp_timeout),
    .eng_data    (eng_data),
    .eng_start   (eng_start),
    .eng_busy    (e_busy),
    .eng_address (e_addr),
    .eng_match   (e_match)
  );

  rom_search_arbiter #(.TIMEOUT(16)) dut_to (
    .clk         (clk),
    .rst_a       (rst2),
    .req         (req2),
    .req_data    (req_data2),
    .grant       (grant2),
    .done        (done2),
    .rsp_address (rsp_address2),
    .rsp_match   (rsp_match2),
    .rsp_timeout (rsp_timeout2),
    .eng_data    (eng_data2),
    .eng_start   (eng_start2),
    .eng_busy    (busy2),
    .eng_address (addr2),
    .eng_match   (match2)
  );

  // Engine: one ROM word per cycle from address 0, stops on hit or at 255.
  always @(posedge clk) begin
    if (!e_busy) begin
      if (eng_start) begin
        e_busy  <= 1'b1;
        e_addr  <= 8'h00;
        e_key   <= eng_data;
        e_match <= 1'b0;
      end
    end else if (rom[e_addr] == e_key) begin
      e_busy  <= 1'b0;
      e_match <= 1'b1;
    end else if (e_addr == 8'hFF) begin
      e_busy  <= 1'b0;
      e_match <= 1'b0;
    end else begin
      e_addr <= e_addr + 8'h01;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count negedges from 'first' until a done pulse; -1 if budget runs out.
  task automatic wait_done(input bit sel, input int first,
                           input int budget, output int c_out);
    c_out = -1;
    for (int c = first; c <= budget; c++) begin
      @(negedge clk);
      if (sel ? |done2 : |done) begin
        c_out = c;
        break;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'(a);
    rom[3]     = 8'h5A;
    rom[8'hEE] = 8'h03;

    rst = 1'b1; rst2 = 1'b1;
    req = '0; req2 = '0;
    req_data = '0; req_data2 = '0;
    busy2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", {28'd0, grant}, 32'h0);
    chk("rst_done", {28'd0, done}, 32'h0);
    chk("rst_start", {31'd0, eng_start}, 32'h0);
    chk("rst_data", {24'd0, eng_data}, 32'h0);
    chk("rst_rsp", {22'd0, rsp_address, rsp_match, rsp_timeout}, 32'h0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // Single request, hit at address 3
    req_data[7:0] = 8'h5A;
    req[0] = 1'b1;
    @(negedge clk);
    chk("single_start", {31'd0, eng_start}, 32'h1);
    chk("single_grant", {28'd0, grant}, 32'h1);
    chk("single_key", {24'd0, eng_data}, 32'h5A);
    wait_done(1'b0, 2, 50, cyc);
    chk("single_lat", cyc, 7);
    chk("single_done", {28'd0, done}, 32'h1);
    chk("single_addr", {24'd0, rsp_address}, 32'h3);
    chk("single_match", {31'd0, rsp_match}, 32'h1);
    chk("single_to", {31'd0, rsp_timeout}, 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("idle_grant", {28'd0, grant}, 32'h0);
    chk("idle_done", {28'd0, done}, 32'h0);

    // Miss: key 0xEE is nowhere in the ROM
    req_data[23:16] = 8'hEE;
    req[2] = 1'b1;
    wait_done(1'b0, 1, 400, cyc);
    chk("miss_lat", cyc, 259);
    chk("miss_done", {28'd0, done}, 32'h4);
    chk("miss_match", {31'd0, rsp_match}, 32'h0);
    chk("miss_to", {31'd0, rsp_timeout}, 32'h0);
    req[2] = 1'b0;

    // Contention from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_data = 32'h04020100;
    req = 4'hF;
    wait_done(1'b0, 1, 50, cyc);
    chk("cont_0", {28'd0, done}, 32'h1);
    chk("cont_0_addr", {24'd0, rsp_address}, 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cont_1_grant", {28'd0, grant}, 32'h2);
    req[0] = 1'b1;
    wait_done(1'b0, 1, 50, cyc);
    chk("cont_1", {28'd0, done}, 32'h2);
    chk("cont_1_addr", {24'd0, rsp_address}, 32'h1);
    req[1] = 1'b0;
    wait_done(1'b0, 1, 50, cyc);
    chk("cont_2", {28'd0, done}, 32'h4);
    chk("cont_2_addr", {24'd0, rsp_address}, 32'h2);
    req[2] = 1'b0;
    wait_done(1'b0, 1, 50, cyc);
    chk("cont_3", {28'd0, done}, 32'h8);
    chk("cont_3_addr", {24'd0, rsp_address}, 32'h4);
    req[3] = 1'b0;
    wait_done(1'b0, 1, 50, cyc);
    chk("cont_0b", {28'd0, done}, 32'h1);
    chk("cont_0b_addr", {24'd0, rsp_address}, 32'h0);
    req[0] = 1'b0;

    // Key stability for requester 1
    @(negedge clk);
    req_data[15:8] = 8'h80;
    req[1] = 1'b1;
    @(negedge clk);
    chk("stab_key", {24'd0, eng_data}, 32'h80);
    chk("stab_grant", {28'd0, grant}, 32'h2);
    @(negedge clk);
    req_data[15:8] = 8'h10;
    @(negedge clk);
    chk("stab_hold", {24'd0, eng_data}, 32'h80);
    wait_done(1'b0, 1, 300, cyc);
    chk("stab_addr", {24'd0, rsp_address}, 32'h80);
    chk("stab_hold2", {24'd0, eng_data}, 32'h80);
    req[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b1;
    @(negedge clk);
    chk("stab_newkey", {24'd0, eng_data}, 32'h10);
    wait_done(1'b0, 1, 100, cyc);
    chk("stab_newaddr", {24'd0, rsp_address}, 32'h10);
    req[1] = 1'b0;

    // Timeout on the TIMEOUT=16 instance
    req_data2[23:16] = 8'h33;
    req2[2] = 1'b1;
    @(negedge clk);
    chk("to_start", {31'd0, eng_start2}, 32'h1);
    chk("to_grant", {28'd0, grant2}, 32'h4);
    busy2 = 1'b1;
    wait_done(1'b1, 2, 60, cyc);
    chk("to_lat", cyc, 18);
    chk("to_done", {28'd0, done2}, 32'h4);
    chk("to_flag", {31'd0, rsp_timeout2}, 32'h1);
    chk("to_match", {31'd0, rsp_match2}, 32'h0);
    chk("to_addr", {24'd0, rsp_address2}, 32'h0);
    req2[2] = 1'b0;
    busy2 = 1'b0;

    // Reset while running; engine stays busy 5 more cycles
    @(negedge clk);
    req_data2[15:8] = 8'h21;
    req2[1] = 1'b1;
    @(negedge clk);
    chk("rr_start", {31'd0, eng_start2}, 32'h1);
    busy2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_grant_pre", {28'd0, grant2}, 32'h2);
    rst2 = 1'b1;
    #1;
    chk("rr_grant", {28'd0, grant2}, 32'h0);
    chk("rr_data", {24'd0, eng_data2}, 32'h0);
    chk("rr_flags",
        {28'd0, eng_start2, rsp_match2, rsp_timeout2, |done2}, 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_wait", {27'd0, eng_start2, grant2}, 32'h0);
    end
    busy2 = 1'b0;
    @(negedge clk);
    chk("rr_restart", {31'd0, eng_start2}, 32'h1);
    chk("rr_regrant", {28'd0, grant2}, 32'h2);
    chk("rr_rekey", {24'd0, eng_data2}, 32'h21);
    busy2 = 1'b1;
    @(negedge clk);
    busy2 = 1'b0;
    wait_done(1'b1, 1, 30, cyc);
    chk("rr_done", {28'd0, done2}, 32'h2);
    chk("rr_rsp", {22'd0, rsp_address2, rsp_match2, rsp_timeout2},
        {22'd0, 8'h77, 1'b1, 1'b0});
    req2[1] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
